// File: rtl/wiredleg_div_pkg.sv
// Shared types and constants for the two-requester divider scheduler.
//   DIV_W    : operand / result width
//   DIV_LAT  : iterations of the shared divider (busy cycles per divide)
//   DIV_NREQ : number of issue ports
//   DIV0_QUO : quotient returned for a divide by zero
package wiredleg_div_pkg;

  localparam int unsigned DIV_W    = 32;
  localparam int unsigned DIV_LAT  = 32;
  localparam int unsigned DIV_NREQ = 2;
  localparam int unsigned CNT_W    = $clog2(DIV_LAT + 1);

  localparam logic [DIV_W-1:0] DIV0_QUO = 32'hFFFF_FFFF;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } sched_state_e;

  // Operation payload of one issue port, as seen by the divider.
  typedef struct packed {
    logic [DIV_W-1:0] a;
    logic [DIV_W-1:0] b;
    logic             sign;
    logic             rem;
  } div_req_t;

  // Result for a zero divisor: all-ones quotient, dividend as remainder.
  function automatic logic [DIV_W-1:0] div0_result(input logic [DIV_W-1:0] a,
                                                   input logic             rem);
    return rem ? a : DIV0_QUO;
  endfunction

endpackage

// File: rtl/wiredleg_div_sched_if.sv
// Request/response bundle between the issue ports and the divider scheduler.
//   master : requester side (drives req_*, flush, rsp_ready)
//   slave  : scheduler side (drives req_ready, rsp_*)
interface wiredleg_div_sched_if #(
  parameter int unsigned TAG_W = 4
);
  import wiredleg_div_pkg::*;

  logic [DIV_NREQ-1:0]            req_valid;
  logic [DIV_NREQ-1:0]            req_ready;
  logic [DIV_NREQ-1:0][DIV_W-1:0] req_a;
  logic [DIV_NREQ-1:0][DIV_W-1:0] req_b;
  logic [DIV_NREQ-1:0]            req_sign;
  logic [DIV_NREQ-1:0]            req_rem;
  logic [DIV_NREQ-1:0][TAG_W-1:0] req_tag;
  logic [DIV_NREQ-1:0]            flush;
  logic [DIV_NREQ-1:0]            rsp_valid;
  logic [DIV_NREQ-1:0]            rsp_ready;
  logic [DIV_NREQ-1:0][DIV_W-1:0] rsp_data;
  logic [DIV_NREQ-1:0][TAG_W-1:0] rsp_tag;

  modport master (
    output req_valid, req_a, req_b, req_sign, req_rem, req_tag, flush, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_tag
  );

  modport slave (
    input  req_valid, req_a, req_b, req_sign, req_rem, req_tag, flush, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_tag
  );

endinterface

// File: rtl/wiredleg_div_simp.sv
// Fixed-latency restoring divider, one quotient bit per cycle.
//   clk, rst_n : clock, synchronous active-low reset
//   start      : load operands (restarts an operation in flight)
//   sign, a, b : signedness, dividend, divisor
//   busy       : high for DIV_LAT cycles after start
//   quo, rem   : registered results, valid once busy falls
module wiredleg_div_simp
  import wiredleg_div_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sign,
  input  logic [DIV_W-1:0] a,
  input  logic [DIV_W-1:0] b,
  output logic             busy,
  output logic [DIV_W-1:0] quo,
  output logic [DIV_W-1:0] rem
);

  logic [CNT_W-1:0] cnt_q;
  logic [DIV_W-1:0] acc_q;
  logic [DIV_W-1:0] dvd_q;
  logic [DIV_W-1:0] dvs_q;
  logic             neg_quo_q;
  logic             neg_rem_q;

  logic [DIV_W:0]   trial;
  logic [DIV_W:0]   dvs_ext;
  logic             ge;
  logic [DIV_W-1:0] acc_nxt;
  logic [DIV_W-1:0] dvd_nxt;

  // One restoring step on magnitudes; trial needs one extra bit.
  always_comb begin
    trial   = {acc_q, dvd_q[DIV_W-1]};
    dvs_ext = {1'b0, dvs_q};
    ge      = (trial >= dvs_ext);
    acc_nxt = ge ? DIV_W'(trial - dvs_ext) : DIV_W'(trial);
    dvd_nxt = {dvd_q[DIV_W-2:0], ge};
  end

  // Operand load, iteration, and sign fix-up on the last step.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      cnt_q     <= '0;
      acc_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      quo       <= '0;
      rem       <= '0;
    end else if (start) begin
      busy      <= 1'b1;
      cnt_q     <= CNT_W'(DIV_LAT);
      acc_q     <= '0;
      dvd_q     <= (sign && a[DIV_W-1]) ? -a : a;
      dvs_q     <= (sign && b[DIV_W-1]) ? -b : b;
      neg_quo_q <= sign && (a[DIV_W-1] ^ b[DIV_W-1]);
      neg_rem_q <= sign && a[DIV_W-1];
    end else if (busy) begin
      acc_q <= acc_nxt;
      dvd_q <= dvd_nxt;
      cnt_q <= cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        busy <= 1'b0;
        quo  <= neg_quo_q ? -dvd_nxt : dvd_nxt;
        rem  <= neg_rem_q ? -acc_nxt : acc_nxt;
      end
    end
  end

endmodule

// File: rtl/wiredleg_div_sched.sv
// Shares one iterative divider between two issue ports: round-robin grant,
// divide-by-zero bypass, per-port response registers and per-port flush.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of wiredleg_div_sched_if (requests, flush, responses)
module wiredleg_div_sched
  import wiredleg_div_pkg::*;
#(
  parameter int unsigned TAG_W = 4
) (
  input logic                  clk,
  input logic                  rst,
  wiredleg_div_sched_if.slave  bus
);

  sched_state_e state_q, state_d;

  logic             rr_q;
  logic             owner_q;
  logic             own_rem_q;
  logic [TAG_W-1:0] own_tag_q;

  logic [DIV_NREQ-1:0]            rsp_valid_q;
  logic [DIV_NREQ-1:0][DIV_W-1:0] rsp_data_q;
  logic [DIV_NREQ-1:0][TAG_W-1:0] rsp_tag_q;

  logic [DIV_NREQ-1:0] avail;
  logic [DIV_NREQ-1:0] elig;
  logic [DIV_NREQ-1:0] ready_c;
  logic [DIV_NREQ-1:0] acc;
  logic                acc_any;
  logic                acc_idx;
  div_req_t            sel;
  logic                div_start;
  logic                bypass;
  logic                capture;

  logic             div_busy;
  logic [DIV_W-1:0] div_quo;
  logic [DIV_W-1:0] div_rem;

  // Grant, divider launch and FSM next state.
  // A port's ready looks only at the other port's valid, so ready never
  // depends combinationally on its own valid.
  always_comb begin
    state_d   = state_q;
    ready_c   = '0;
    div_start = 1'b0;
    bypass    = 1'b0;
    capture   = 1'b0;

    avail = ~rsp_valid_q & ~bus.flush;
    elig  = avail & bus.req_valid;

    if (state_q == IDLE && !rst) begin
      ready_c[0] = avail[0] & (!rr_q | !elig[1]);
      ready_c[1] = avail[1] & ( rr_q | !elig[0]);
    end

    acc     = ready_c & bus.req_valid;
    acc_any = |acc;
    acc_idx = acc[1];

    sel.a    = bus.req_a[acc_idx];
    sel.b    = bus.req_b[acc_idx];
    sel.sign = bus.req_sign[acc_idx];
    sel.rem  = bus.req_rem[acc_idx];

    case (state_q)
      IDLE: begin
        if (acc_any) begin
          if (sel.b != '0) begin
            div_start = 1'b1;
            state_d   = RUN;
          end else begin
            bypass = 1'b1;
          end
        end
      end
      RUN: begin
        // Flush of the owner abandons the result; the divider runs on harmlessly.
        if (bus.flush[owner_q]) begin
          state_d = IDLE;
        end else if (!div_busy) begin
          capture = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Round-robin pointer and in-flight owner context.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q      <= 1'b0;
      owner_q   <= 1'b0;
      own_rem_q <= 1'b0;
      own_tag_q <= '0;
    end else begin
      if (acc_any) rr_q <= !acc_idx;
      if (div_start) begin
        owner_q   <= acc_idx;
        own_rem_q <= sel.rem;
        own_tag_q <= bus.req_tag[acc_idx];
      end
    end
  end

  // Per-port response registers; flush beats capture, bypass and drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_tag_q   <= '0;
    end else begin
      for (int unsigned i = 0; i < DIV_NREQ; i++) begin
        if (bus.flush[i]) begin
          rsp_valid_q[i] <= 1'b0;
        end else if (capture && owner_q == 1'(i)) begin
          rsp_valid_q[i] <= 1'b1;
          rsp_data_q[i]  <= own_rem_q ? div_rem : div_quo;
          rsp_tag_q[i]   <= own_tag_q;
        end else if (bypass && acc_idx == 1'(i)) begin
          rsp_valid_q[i] <= 1'b1;
          rsp_data_q[i]  <= div0_result(sel.a, sel.rem);
          rsp_tag_q[i]   <= bus.req_tag[acc_idx];
        end else if (bus.rsp_ready[i]) begin
          rsp_valid_q[i] <= 1'b0;
        end
      end
    end
  end

  assign bus.req_ready = ready_c;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_tag   = rsp_tag_q;

  wiredleg_div_simp u_div (
    .clk   (clk),
    .rst_n (!rst),
    .start (div_start),
    .sign  (sel.sign),
    .a     (sel.a),
    .b     (sel.b),
    .busy  (div_busy),
    .quo   (div_quo),
    .rem   (div_rem)
  );

endmodule

// File: tb/tb_wiredleg_div_sched.sv
// Self-checking bench for wiredleg_div_sched: expected responses are queued
// per port at accept time and compared when the response is consumed.
module tb_wiredleg_div_sched;
  import wiredleg_div_pkg::*;

  localparam int unsigned TAG_W = 4;

  typedef struct {
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
    int               lat;
    int               acc_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wiredleg_div_sched_if #(.TAG_W(TAG_W)) bus ();

  wiredleg_div_sched #(.TAG_W(TAG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   cyc;
  int   n_chk;
  int   n_pass;
  int   start_cnt;
  exp_t sb [2][$];
  exp_t mon_e;
  logic [1:0] prev_v;

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", tag, got, want, cyc);
  endtask

  // Reference result from language-level division.
  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic s, input logic r);
    if (b == 32'd0) return r ? a : 32'hFFFF_FFFF;
    if (s) return r ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
    return r ? (a % b) : (a / b);
  endfunction

  // Scoreboard monitor: push on accept, check latency on arrival, compare on consume.
  always @(negedge clk) begin
    if (!rst) begin
      if (dut.div_start) start_cnt++;
      for (int i = 0; i < 2; i++) begin
        if (bus.flush[i]) sb[i].delete();
        if (bus.req_valid[i] && bus.req_ready[i]) begin
          mon_e.data    = model(bus.req_a[i], bus.req_b[i], bus.req_sign[i], bus.req_rem[i]);
          mon_e.tag     = bus.req_tag[i];
          mon_e.lat     = (bus.req_b[i] == 32'd0) ? 1 : 34;
          mon_e.acc_cyc = cyc;
          sb[i].push_back(mon_e);
        end
        if (bus.rsp_valid[i] && !prev_v[i]) begin
          check($sformatf("rsp_expected%0d", i), 32'(sb[i].size() != 0), 32'd1);
          if (sb[i].size() != 0)
            check($sformatf("latency%0d", i), 32'(cyc - sb[i][0].acc_cyc), 32'(sb[i][0].lat));
        end
        if (bus.rsp_valid[i] && bus.rsp_ready[i] && sb[i].size() != 0) begin
          mon_e = sb[i].pop_front();
          check($sformatf("data%0d", i), bus.rsp_data[i], mon_e.data);
          check($sformatf("tag%0d", i), 32'(bus.rsp_tag[i]), 32'(mon_e.tag));
        end
      end
      prev_v <= bus.rsp_valid;
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic raise(input int p, input logic [31:0] a, input logic [31:0] b,
                       input logic s, input logic r, input logic [TAG_W-1:0] t);
    bus.req_a[p]     = a;
    bus.req_b[p]     = b;
    bus.req_sign[p]  = s;
    bus.req_rem[p]   = r;
    bus.req_tag[p]   = t;
    bus.req_valid[p] = 1'b1;
  endtask

  task automatic wait_acc(input int p, output int c);
    c = -1;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (bus.req_valid[p] && bus.req_ready[p]) begin
        c = cyc;
        break;
      end
    end
    if (c < 0) check($sformatf("accept_timeout%0d", p), 32'd0, 32'd1);
    sync();
    bus.req_valid[p] = 1'b0;
  endtask

  task automatic issue(input int p, input logic [31:0] a, input logic [31:0] b,
                       input logic s, input logic r, input logic [TAG_W-1:0] t, output int c);
    sync();
    raise(p, a, b, s, r, t);
    wait_acc(p, c);
  endtask

  task automatic wait_idle();
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (sb[0].size() == 0 && sb[1].size() == 0 && bus.rsp_valid == 2'b00) begin
        ok = 1'b1;
        break;
      end
    end
    check("drain", 32'(ok), 32'd1);
  endtask

  int c0, c1, r0, s0;
  logic [31:0] ra, rb;
  logic        rs, rr_bit;
  int          rp;

  initial begin
    n_chk = 0; n_pass = 0; start_cnt = 0; prev_v = 2'b00;
    rst = 1'b1;
    bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0; bus.req_sign = '0;
    bus.req_rem = '0; bus.req_tag = '0; bus.flush = '0; bus.rsp_ready = 2'b11;

    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_data0", bus.rsp_data[0], 32'd0);
    check("rst_rsp_data1", bus.rsp_data[1], 32'd0);
    check("rst_rsp_tag", 32'(bus.rsp_tag), 32'd0);
    rst = 1'b0;

    // Both ports at once after reset: port 0 first, port 1 one divide later.
    sync();
    raise(0, 32'd100, 32'd7, 1'b0, 1'b0, 4'h1);
    raise(1, 32'd200, 32'd9, 1'b0, 1'b0, 4'h2);
    wait_acc(0, c0);
    wait_acc(1, c1);
    check("pair_gap", 32'(c1 - c0), 32'd34);
    wait_idle();

    issue(0, 32'd100, 32'd7, 1'b0, 1'b1, 4'h5, c0);
    wait_idle();

    // Divide by zero bypass, no divider start.
    s0 = start_cnt;
    issue(0, 32'h1234, 32'd0, 1'b0, 1'b0, 4'h7, c0);
    wait_idle();
    issue(0, 32'h1234, 32'd0, 1'b1, 1'b1, 4'h8, c0);
    wait_idle();
    check("bypass_no_start", 32'(start_cnt - s0), 32'd0);

    // Two bypasses: pointer is at port 1, port 0 follows next cycle.
    sync();
    raise(0, 32'hCAFE_0000, 32'd0, 1'b0, 1'b1, 4'h3);
    raise(1, 32'h0000_BEEF, 32'd0, 1'b1, 1'b0, 4'h4);
    wait_acc(1, c1);
    wait_acc(0, c0);
    check("bypass_pair_gap", 32'(c0 - c1), 32'd1);
    wait_idle();

    // Next normal pair: pointer is at port 1 again.
    sync();
    raise(0, 32'd1000, 32'd33, 1'b0, 1'b0, 4'h6);
    raise(1, 32'hFFFF_FF00, 32'd7, 1'b1, 1'b1, 4'h9);
    wait_acc(1, c1);
    wait_acc(0, c0);
    check("rr_pair_gap", 32'(c0 - c1), 32'd34);
    wait_idle();

    // Signed -7 / 2 on port 1.
    issue(1, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, 4'hA, c1);
    wait_idle();
    issue(1, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, 4'hB, c1);
    wait_idle();

    // Flush the owner in RUN cycle 10; pending port 1 goes next cycle.
    issue(0, 32'd5000, 32'd3, 1'b0, 1'b0, 4'hC, c0);
    raise(1, 32'hFFFF_FF00, 32'd16, 1'b1, 1'b1, 4'hD);
    while (cyc < c0 + 10) sync();
    bus.flush[0] = 1'b1;
    sync();
    bus.flush[0] = 1'b0;
    wait_acc(1, c1);
    check("flush_reaccept", 32'(c1 - c0), 32'd11);
    wait_idle();
    check("flush_no_rsp0", 32'(bus.rsp_valid[0]), 32'd0);

    // Backpressure on port 0 while port 1 is served.
    bus.rsp_ready[0] = 1'b0;
    issue(0, 32'd1000, 32'd10, 1'b0, 1'b0, 4'hE, c0);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus.rsp_valid[0]) break;
    end
    check("bp_rsp0_valid", 32'(bus.rsp_valid[0]), 32'd1);
    sync();
    raise(0, 32'd77, 32'd5, 1'b0, 1'b1, 4'hF);
    issue(1, 32'd999, 32'd4, 1'b0, 1'b0, 4'h1, c1);
    repeat (5) begin
      @(negedge clk);
      check("bp_req_ready0", 32'(bus.req_ready[0]), 32'd0);
    end
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (sb[1].size() == 0) break;
    end
    check("bp_port1_done", 32'(sb[1].size()), 32'd0);
    check("bp_rsp0_held", 32'(bus.rsp_valid[0]), 32'd1);
    sync();
    bus.rsp_ready[0] = 1'b1;
    r0 = cyc;
    wait_acc(0, c0);
    check("bp_reaccept", 32'(c0 - r0), 32'd1);
    wait_idle();

    // Mixed operands on random ports.
    for (int n = 0; n < 12; n++) begin
      rp = int'($urandom_range(0, 1));
      ra = $urandom;
      rs = 1'($urandom_range(0, 1));
      rr_bit = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) rb = 32'd0;
      else if ($urandom_range(0, 1) == 1) rb = $urandom;
      else rb = 32'($urandom_range(1, 100));
      if (rs && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd3;
      issue(rp, ra, rb, rs, rr_bit, 4'(n), c0);
      wait_idle();
    end

    check("sb_empty0", 32'(sb[0].size()), 32'd0);
    check("sb_empty1", 32'(sb[1].size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/wiredleg_div_sched.md
# wiredleg_div_sched

Two-requester scheduler that shares one 32-bit fixed-latency iterative divider (`wiredleg_div_simp`) between two issue ports, e.g. two pipeline slots or an ALU and a CSR path. It arbitrates requests round-robin, drives the divider start/operands, and tracks completion. It captures the selected quotient or remainder into a per-requester response register and supports per-requester flush. Divide-by-zero bypasses the divider with a one-cycle response.

## Interface
- `TAG_W`, default 4: width of the opaque request tag echoed on the response.
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous active-high reset.
- `req_valid`  in  2  per-requester request valid; index 0 and index 1.
- `req_ready`  out  2  per-requester accept; a transfer happens when valid && ready.
- `req_a`  in  2x32  dividend.
- `req_b`  in  2x32  divisor.
- `req_sign`  in  2  1 = signed divide, 0 = unsigned.
- `req_rem`  in  2  1 = return remainder, 0 = return quotient.
- `req_tag`  in  2xTAG_W  tag, returned unchanged.
- `flush`  in  2  kill any accepted-but-unreturned operation of that requester.
- `rsp_valid`  out  2  response register full.
- `rsp_ready`  in  2  response consumed when valid && ready.
- `rsp_data`  out  2x32  selected quotient or remainder.
- `rsp_tag`  out  2xTAG_W  tag of the response.

## Operation
- FSM states: IDLE (divider free) and RUN (divider owned by `owner`).
- Eligibility: requester i is eligible in IDLE when `req_valid[i]`, `!rsp_valid[i]` and `!flush[i]`.
- Arbitration: round-robin pointer `rr`. If both are eligible, grant `rr`. After each grant, `rr` moves to the other requester. Reset value of `rr` is 0.
- `req_ready[i]` is 1 only in IDLE, for the granted requester. It is combinational from state, eligibility and `rr`.
- Accept with `req_b != 0`:
  - `div_start`=1 in the same cycle, operands muxed directly from the granted port.
  - Latch `owner`, `req_rem` and `req_tag`; go to RUN.
- Accept with `req_b == 0` (bypass):
  - Divider not started; stay in IDLE.
  - Response register of that requester is loaded next edge.
  - Data: quotient = 0xFFFFFFFF; remainder = `req_a` unchanged. Independent of `req_sign`.
- RUN: wait until `div_busy`==0, then capture `rem` or `quo` of the divider into `rsp_data[owner]` and `rsp_tag[owner]`. Set `rsp_valid[owner]` and return to IDLE.
- Response register holds until `rsp_ready[i]`. No overflow is possible, because a requester is granted only with its response register empty.
- Flush[i]:
  - Clears `rsp_valid[i]`.
  - If in RUN with `owner`==i, returns to IDLE next edge and the result is discarded. The divider is not reset; the next `div_start` restarts it.
  - Flush wins over `req_valid[i]` in the same cycle.
  - Flush wins over capture in the same cycle.
- Flush of the non-owner never disturbs the in-flight operation.
- `rsp_ready[i]` together with a capture for i in the same cycle cannot occur, because the register was empty at grant.

## Timing
- Reset values: `req_ready`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_tag`=0, state IDLE, `rr`=0.
- Divider reset is tied to `!rst` on its synchronous active-low input.
- Normal divide:
  - Accept in cycle 0; divider busy in cycles 1..32.
  - Result stable in cycle 33 and captured at the end of cycle 33.
  - `rsp_valid` high from cycle 34; latency 34.
  - IDLE again in cycle 34, so the next accept is possible in cycle 34. Throughput is 1 divide per 34 cycles.
- Bypass: accept in cycle 0, `rsp_valid` in cycle 1. A bypass for the other requester may be accepted the following IDLE cycle.
- Flush in cycle k of RUN: IDLE in cycle k+1, new accept possible in cycle k+1.
- Response register is fully registered. `req_ready` is combinational, with no dependency on `req_valid` of the same port.

## Structure
- Shared package `wiredleg_div_pkg`:
  - state enum {IDLE, RUN};
  - `DIV_LAT` = 32;
  - `DIV_NREQ` = 2;
  - bypass constants `DIV0_QUO` = 32'hFFFF_FFFF.
- One sub-module: the `wiredleg_div_simp` instance.
- Everything else (arbiter, FSM, response registers) stays flat in this module.

## Test plan
- Unsigned, port 0: 100 / 7 quotient → `rsp_data[0]`=14 at cycle 34. Repeat with `req_rem`=1 → 2, tag echoed.
- Signed, port 1: -7 / 2 → quotient 0xFFFFFFFD; remainder → 0xFFFFFFFF.
- Both ports valid at cycle 0 after reset:
  - port 0 granted first; port 1 accepted at cycle 34;
  - the next pair is granted 1 then 0, by round-robin.
- Bypass: port 0 a=0x1234, b=0, quotient → 0xFFFFFFFF in cycle 1. Same with `req_rem`=1 → 0x1234. Divider start never pulses.
- Flush of owner at RUN cycle 10 → no response, IDLE at cycle 11. Pending port 1 is accepted at cycle 11 and returns the correct result 34 cycles later.
- Backpressure: hold `rsp_ready[0]`=0.
  - `req_ready[0]` stays 0 and port 1 is still served.
  - Releasing `rsp_ready[0]` drains one entry, and port 0 is accepted the next cycle.
